alu_ctrl_seq: RTL

Parametrised, registered ALU control unit for the MIPS datapath: decodes `ALUOp`/`funct` into an ALU operation code and sequences multi-cycle multiply/divide instructions. Single-cycle ops issue with 1-cycle latency. MULT/DIV hold the pipeline via `busy` for a fixed latency, then pulse `mdu_done`. Sits between the main control/ID stage and the ALU/MDU in EX.

---
 rtl/alu_ctrl_pkg.sv | 34 +++
 rtl/mdu_cycle_counter.sv | 36 +++
 rtl/alu_ctrl_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared op codes, funct codes, ALUOp classes and FSM state type for alu_ctrl_seq.
`timescale 1ns/1ps
package alu_ctrl_pkg;

  localparam int OP_NOP  = 0;
  localparam int OP_ADD  = 27;
  localparam int OP_SUB  = 28;
  localparam int OP_AND  = 29;
  localparam int OP_OR   = 30;
  localparam int OP_SLT  = 31;
  localparam int OP_SLL  = 32;
  localparam int OP_MULT = 33;
  localparam int OP_DIV  = 34;

  localparam int F_ADD  = 21;
  localparam int F_SUB  = 22;
  localparam int F_AND  = 23;
  localparam int F_OR   = 24;
  localparam int F_SLT  = 25;
  localparam int F_SLL  = 26;
  localparam int F_MULT = 27;
  localparam int F_DIV  = 28;

  // Any class other than these two (ALUOp[1] set) decodes the funct field.
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_cycle_counter.sv
// Down-counter timing a multi-cycle MDU op; load wins over enable, holds at zero.
// zero_o is a registered-state flag, no combinational path from the inputs.
`timescale 1ns/1ps
module mdu_cycle_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control: decode ALUOp/funct, 1-cycle issue; MULT/DIV hold busy for LAT cycles
// then pulse mdu_done. ready = !busy; valid_in while busy is ignored (upstream holds).
`timescale 1ns/1ps
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [1:0]         ALUOp,
  input  logic [FUNCT_W-1:0] funct,
  output logic               ready,
  output logic [OP_W-1:0]    operation,
  output logic               op_valid,
  output logic               illegal,
  output logic               busy,
  output logic               mdu_start,
  output logic               mdu_done
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   operation_q, operation_d;
  logic              op_valid_q, op_valid_d;
  logic              illegal_q, illegal_d;
  logic              mdu_start_q, mdu_start_d;
  logic              mdu_done_q, mdu_done_d;

  logic [OP_W-1:0]   dec_op;
  logic              dec_illegal, dec_mul, dec_div;
  logic              accept;
  logic              cnt_load, cnt_zero;
  logic [CNT_W-1:0]  cnt_load_val;

  always_comb begin
    dec_op      = OP_W'(OP_NOP);
    dec_illegal = 1'b0;
    dec_mul     = 1'b0;
    dec_div     = 1'b0;
    if (ALUOp == ALUOP_ADD) begin
      dec_op = OP_W'(OP_ADD);
    end else if (ALUOp == ALUOP_SUB) begin
      dec_op = OP_W'(OP_SUB);
    end else begin
      case (funct)
        FUNCT_W'(F_ADD):  dec_op = OP_W'(OP_ADD);
        FUNCT_W'(F_SUB):  dec_op = OP_W'(OP_SUB);
        FUNCT_W'(F_AND):  dec_op = OP_W'(OP_AND);
        FUNCT_W'(F_OR):   dec_op = OP_W'(OP_OR);
        FUNCT_W'(F_SLT):  dec_op = OP_W'(OP_SLT);
        FUNCT_W'(F_SLL):  dec_op = OP_W'(OP_SLL);
        FUNCT_W'(F_MULT): begin dec_op = OP_W'(OP_MULT); dec_mul = 1'b1; end
        FUNCT_W'(F_DIV):  begin dec_op = OP_W'(OP_DIV);  dec_div = 1'b1; end
        default:          dec_illegal = 1'b1;
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign ready  = !busy;
  assign accept = valid_in && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      operation_q <= '0;
      op_valid_q  <= 1'b0;
      illegal_q   <= 1'b0;
      mdu_start_q <= 1'b0;
      mdu_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      operation_q <= operation_d;
      op_valid_q  <= op_valid_d;
      illegal_q   <= illegal_d;
      mdu_start_q <= mdu_start_d;
      mdu_done_q  <= mdu_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && dec_mul) begin
          state_d = MUL;
        end else if (accept && dec_div) begin
          state_d = DIV;
        end
      end
      MUL, DIV: begin
        if (cnt_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    operation_d  = operation_q;
    op_valid_d   = 1'b0;
    illegal_d    = 1'b0;
    mdu_start_d  = 1'b0;
    mdu_done_d   = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          operation_d = dec_op;
          op_valid_d  = 1'b1;
          illegal_d   = dec_illegal;
          if (dec_mul || dec_div) begin
            mdu_start_d  = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = dec_mul ? MUL_LOAD : DIV_LOAD;
          end
        end
      end
      MUL, DIV: begin
        // The edge that sees an already-zero count is the completion edge.
        if (cnt_zero) mdu_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  mdu_cycle_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .en_i      (busy),
    .zero_o    (cnt_zero)
  );

  assign operation = operation_q;
  assign op_valid  = op_valid_q;
  assign illegal   = illegal_q;
  assign mdu_start = mdu_start_q;
  assign mdu_done  = mdu_done_q;

endmodule
